data_sram_responder: RTL and testbench

Slave-side model of the CPU data memory port: accepts requests from the execute stage on the data SRAM request channel and returns read data to the memory stage on `data_sram_rdata`. It is the responder end of the interface whose read side the memory stage consumes.
- Holds an internal word array.
- Commits writes with byte strobes.
- Returns responses in order after a programmable latency, with up to two requests outstanding.
- Used as the data memory in simulation and FPGA builds of the pipeline.

---
 rtl/data_sram_responder.sv | 96 +++++++++
 tb/tb_data_sram_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word array with byte-strobed writes and a 2-deep
// in-order response queue whose entries respond a fixed LATENCY after acceptance.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int unsigned Words   = 1 << ADDR_WIDTH;
  localparam logic [2:0]  LoadCnt = 3'(LATENCY - 1);

  logic [31:0] mem [Words];

  logic [1:0]  count_q;
  logic        head_q;
  logic        tail_q;
  logic [31:0] ent_data_q [2];
  logic [2:0]  ent_cnt_q  [2];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic                  ent_valid [2];

  // size only documents the access; the high address bits alias by design
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr};

  assign idx = data_sram_addr[ADDR_WIDTH+1:2];

  // Queue-derived handshake and response outputs; addr_ok never looks at req
  always_comb begin
    data_sram_data_ok = (count_q != 2'd0) && (ent_cnt_q[head_q] == 3'd0);
    data_sram_addr_ok = (count_q != 2'd2) || data_sram_data_ok;
    data_sram_rdata   = data_sram_data_ok ? ent_data_q[head_q] : 32'h0;
    accept            = data_sram_req && data_sram_addr_ok;
  end

  // Entry i is occupied when the queue is full, or it is the sole entry at the head
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ent_valid[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(i)));
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Response queue: push on accept, pop on data_ok, countdowns saturate at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_data_q[i] <= 32'h0;
        ent_cnt_q[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        // When full and popping, tail equals head, so the freed slot is reloaded
        if (accept && (tail_q == 1'(i))) begin
          // Read data is the array value before this edge's write
          ent_data_q[i] <= data_sram_wr ? 32'h0 : mem[idx];
          ent_cnt_q[i]  <= LoadCnt;
        end else if (ent_valid[i] && (ent_cnt_q[i] != 3'd0)) begin
          ent_cnt_q[i] <= ent_cnt_q[i] - 3'd1;
        end
      end
      if (accept)            tail_q <= ~tail_q;
      if (data_sram_data_ok) head_q <= ~head_q;
      unique case ({accept, data_sram_data_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench: dut0 runs LATENCY=1, dut1 runs LATENCY=3. Stimulus pushes expected
// responses (data and due cycle) into per-DUT queues; monitors pop on data_ok.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn   [2];
  logic        req      [2];
  logic        wr       [2];
  logic [1:0]  size     [2];
  logic [3:0]  wstrb    [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic        addr_ok  [2];
  logic        data_ok  [2];
  logic [31:0] rdata    [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   last_due [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut0 (
    .clk(clk), .resetn(resetn[0]), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_size(size[0]), .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]),
    .data_sram_wdata(wdata[0]), .data_sram_addr_ok(addr_ok[0]),
    .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0])
  );

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut1 (
    .clk(clk), .resetn(resetn[1]), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_size(size[1]), .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]),
    .data_sram_wdata(wdata[1]), .data_sram_addr_ok(addr_ok[1]),
    .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1])
  );

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] data);
    exp_t e;
    int   lat;
    lat    = (d == 0) ? 1 : 3;
    e.data = data;
    e.due  = (cyc + lat > last_due[d] + 1) ? cyc + lat : last_due[d] + 1;
    last_due[d] = e.due;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Present a request and hold it until accepted; acc = cycle of acceptance
  task automatic issue(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, output int acc);
    @(posedge clk);
    #1;
    req[d] = 1'b1; wr[d] = w; size[d] = 2'd2; wstrb[d] = s; addr[d] = a; wdata[d] = wd;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (addr_ok[d]) begin
        acc = cyc;
        push_exp(d, exp);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: addr_ok never rose for addr %h", d, a);
      req[d] = 1'b0;
    end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      req[d] = 1'b0;
    end
  endtask

  task automatic monitor(input int d);
    exp_t e;
    if (data_ok[d]) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok dut%0d: got data_ok=1 rdata %h, expected none (cycle %0d)",
                 d, rdata[d], cyc);
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        check("rdata", d, rdata[d], e.data);
        check("resp_cycle", d, cyc, e.due);
      end
    end else begin
      check("rdata_idle_zero", d, rdata[d], 32'h0);
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  int a0, a1, a2;

  initial begin
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0; req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0;
      wstrb[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0; last_due[d] = 0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_addr_ok", d, 32'(addr_ok[d]), 32'h1);
      check("reset_data_ok", d, 32'(data_ok[d]), 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn[0] = 1'b1;
    resetn[1] = 1'b1;

    // LATENCY=1: write then read back-to-back
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, a0);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, a1);
    check("b2b_no_stall", 0, 32'(a1 - a0), 32'd1);
    // Byte strobes
    issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, a0);
    issue(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0, a0);
    issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, a1);
    // Aliasing and zero strobe
    issue(0, 1'b1, 4'hF, 32'h30, 32'h12345678, 32'h0, a0);
    issue(0, 1'b1, 4'hF, 32'h1030, 32'hCAFEF00D, 32'h0, a0);
    issue(0, 1'b0, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, a0);
    issue(0, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 32'h0, a0);
    issue(0, 1'b0, 4'h0, 32'h1030, 32'h0, 32'hCAFEF00D, a0);
    idle(0, 4);

    // LATENCY=3: fill memory, then three consecutive reads
    issue(1, 1'b1, 4'hF, 32'h40, 32'hA5A5A5A5, 32'h0, a0);
    issue(1, 1'b1, 4'hF, 32'h44, 32'h5A5A5A5A, 32'h0, a0);
    issue(1, 1'b1, 4'hF, 32'h48, 32'h01020304, 32'h0, a0);
    idle(1, 8);
    issue(1, 1'b0, 4'h0, 32'h40, 32'h0, 32'hA5A5A5A5, a0);
    issue(1, 1'b0, 4'h0, 32'h44, 32'h0, 32'h5A5A5A5A, a1);
    issue(1, 1'b0, 4'h0, 32'h48, 32'h0, 32'h01020304, a2);
    check("second_accept", 1, 32'(a1 - a0), 32'd1);
    check("third_accept_on_pop", 1, 32'(a2 - a0), 32'd3);
    idle(1, 8);

    // Async reset with two reads outstanding
    issue(1, 1'b0, 4'h0, 32'h40, 32'h0, 32'hA5A5A5A5, a0);
    issue(1, 1'b0, 4'h0, 32'h44, 32'h0, 32'h5A5A5A5A, a1);
    idle(1, 1);
    #2;
    resetn[1] = 1'b0;
    #1;
    check("midreset_addr_ok", 1, 32'(addr_ok[1]), 32'h1);
    check("midreset_data_ok", 1, 32'(data_ok[1]), 32'h0);
    sb1.delete();
    last_due[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn[1] = 1'b1;
    idle(1, 6);
    issue(1, 1'b0, 4'h0, 32'h48, 32'h0, 32'h01020304, a0);
    issue(1, 1'b0, 4'h0, 32'h40, 32'h0, 32'hA5A5A5A5, a0);
    idle(1, 10);

    check("sb0_drained", 0, 32'(sb0.size()), 32'h0);
    check("sb1_drained", 1, 32'(sb1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
